// File: rtl/hazard_pkg.sv
// Shared types and constants for the LEGv8 hazard controller.
//  fwd_sel_t   : EX operand source select (register file, WB writeData3, MEM aluResult)
//  stage_tag_t : per-stage destination tag {valid, regWrite, memRead, rd}
//  XZR_IDX     : zero register index; never a hazard or forwarding source
// Optional build macro used by this block: HAZARD_PERF_EN (adds perf counters).
package hazard_pkg;

    localparam int unsigned RA_W   = 5;
    localparam int unsigned PERF_W = 32;

    localparam logic [RA_W-1:0] XZR_IDX = RA_W'(31);

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    typedef struct packed {
        logic            valid;
        logic            regWrite;
        logic            memRead;
        logic [RA_W-1:0] rd;
    } stage_tag_t;

    // True when the stage will write register r with a real (non-XZR) result.
    function automatic logic writesReg(input stage_tag_t t, input logic [RA_W-1:0] r);
        return t.valid & t.regWrite & (t.rd != XZR_IDX) & (t.rd == r);
    endfunction

endpackage

// File: rtl/hazard_tag_pipe.sv
// Shadow pipeline of destination tags (EX -> MEM -> WB), advanced in lockstep
// with the datapath pipeline registers.
//  clk, reset : pipeline clock, asynchronous active-low reset (clears all tags)
//  flushE     : insert a bubble into EX instead of the ID tag
//  flushM     : insert a bubble into MEM instead of the EX tag
//  idValid    : ID holds a real instruction
//  idTag      : tag of the instruction currently in ID
//  tagE/M/W   : current stage tags
module hazard_tag_pipe
    import hazard_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       flushE,
    input  logic       flushM,
    input  logic       idValid,
    input  stage_tag_t idTag,
    output stage_tag_t tagE,
    output stage_tag_t tagM,
    output stage_tag_t tagW
);

    // Three-stage shift with bubble insertion at EX and MEM.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tagE <= '0;
            tagM <= '0;
            tagW <= '0;
        end else begin
            tagW <= tagM;
            tagM <= flushM ? '0 : tagE;
            tagE <= (flushE | ~idValid) ? '0 : idTag;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage LEGv8 pipeline: load-use stall, taken-branch
// flush, EX operand forwarding and ID write-through selects. All outputs are
// combinational from the internal tag pipeline and the current inputs.
//  clk, reset            : pipeline clock, asynchronous active-low reset
//  id_*                  : decoded fields of the instruction in IF/ID
//  ex_rn, ex_r2          : source registers of the instruction in EX
//  pcsrc_m               : branch taken, resolved in MEM
//  stall_F, stall_D      : hold PC / IF/ID
//  flush_D/E/M           : clear IF/ID, ID/EX, EX/MEM on next edge
//  fwdA_E, fwdB_E        : EX operand selects (00 RF, 01 WB, 10 MEM)
//  fwdA_D, fwdB_D        : ID reads take writeData3
// Build macro HAZARD_PERF_EN adds perf_clr, stall_cnt and flush_cnt.
module hazard_ctrl
    import hazard_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
`ifdef HAZARD_PERF_EN
    input  logic              perf_clr,
    output logic [PERF_W-1:0] stall_cnt,
    output logic [PERF_W-1:0] flush_cnt,
`endif
    input  logic              id_valid,
    input  logic [RA_W-1:0]   id_rn,
    input  logic [RA_W-1:0]   id_r2,
    input  logic              id_use_rn,
    input  logic              id_use_r2,
    input  logic [RA_W-1:0]   id_rd,
    input  logic              id_regWrite,
    input  logic              id_memRead,
    input  logic [RA_W-1:0]   ex_rn,
    input  logic [RA_W-1:0]   ex_r2,
    input  logic              pcsrc_m,
    output logic              stall_F,
    output logic              stall_D,
    output logic              flush_D,
    output logic              flush_E,
    output logic              flush_M,
    output logic [1:0]        fwdA_E,
    output logic [1:0]        fwdB_E,
    output logic              fwdA_D,
    output logic              fwdB_D
);

    stage_tag_t tagE, tagM, tagW;
    stage_tag_t idTag;
    logic       loadUse;
    logic       branchTaken;

    // memRead only matters in EX; the later copies are carried for completeness.
    logic unusedTagBits;
    assign unusedTagBits = &{1'b0, tagM.memRead, tagW.memRead};

    assign idTag = '{valid: 1'b1, regWrite: id_regWrite, memRead: id_memRead, rd: id_rd};

    hazard_tag_pipe u_tagPipe (
        .clk     (clk),
        .reset   (reset),
        .flushE  (flush_E),
        .flushM  (flush_M),
        .idValid (id_valid),
        .idTag   (idTag),
        .tagE    (tagE),
        .tagM    (tagM),
        .tagW    (tagW)
    );

    // MEM result is younger than WB, so it wins.
    function automatic fwd_sel_t fwdSel(input stage_tag_t m, input stage_tag_t w,
                                        input logic [RA_W-1:0] src);
        if (writesReg(m, src))      return FWD_MEM;
        else if (writesReg(w, src)) return FWD_WB;
        else                        return FWD_RF;
    endfunction

    // Keeps every output low while reset is held, including the branch path.
    assign branchTaken = pcsrc_m & reset;

    // Load in EX whose destination is read by the instruction in ID.
    assign loadUse = tagE.valid & tagE.memRead & (tagE.rd != XZR_IDX)
                   & ((id_use_rn & (id_rn == tagE.rd)) | (id_use_r2 & (id_r2 == tagE.rd)));

    // A taken branch squashes the stalled instruction, so it overrides the hold.
    assign stall_F = loadUse & ~branchTaken;
    assign stall_D = loadUse & ~branchTaken;
    assign flush_D = branchTaken;
    assign flush_E = loadUse | branchTaken;
    assign flush_M = branchTaken;

    assign fwdA_E = fwdSel(tagM, tagW, ex_rn);
    assign fwdB_E = fwdSel(tagM, tagW, ex_r2);

    assign fwdA_D = id_use_rn & writesReg(tagW, id_rn);
    assign fwdB_D = id_use_r2 & writesReg(tagW, id_r2);

`ifdef HAZARD_PERF_EN
    // Saturating event counters; clear has priority over counting.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (perf_clr) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_F && (stall_cnt != '1)) stall_cnt <= stall_cnt + PERF_W'(1);
            if (pcsrc_m && (flush_cnt != '1)) flush_cnt <= flush_cnt + PERF_W'(1);
        end
    end
`endif

endmodule
